eight_bit_sync_counter: RTL and testbench

- Free-running 8-bit synchronous binary up-counter with a count-enable input and a carry-out for cascading.
- All flip-flops share one clock.
- Implemented as a chain of toggle stages. Each stage's toggle condition is cnt_en ANDed with all lower count bits, so every bit updates on the same edge.
- Used as a basic timing/event-count building block. Wider counters are built by chaining carry into the next stage's cnt_en.

---
 rtl/eight_bit_sync_counter.sv | 50 +++++
 tb/tb_eight_bit_sync_counter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/eight_bit_sync_counter.sv
// eight_bit_sync_counter
// Free-running synchronous binary up-counter built as a chain of toggle stages.
// Bit i toggles when cnt_en and all lower count bits are 1, so every bit
// updates on the same clock edge. The result is equivalent to +1 arithmetic.
// carry flags the terminal count (all ones) while enabled, for cascading:
// wider counters chain carry into the next stage's cnt_en.
// rstn is a synchronous, active-high clear despite its name.

module eight_bit_sync_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cnt_en,
    output logic [WIDTH-1:0] count,
    output logic             carry
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] toggle;

    // Toggle chain: each stage toggles when enable and all lower bits are set.
    always_comb begin
        logic run;
        toggle  = '0;
        count_d = count_q;
        run     = cnt_en;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            toggle[i]  = run;
            count_d[i] = count_q[i] ^ run;
            run        = run & count_q[i];
        end
    end

    // Count register: synchronous clear has priority over counting.
    always_ff @(posedge clk) begin
        if (rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

    // Terminal-count carry is combinational and deliberately not gated by reset.
    assign carry = toggle[WIDTH-1] & count_q[WIDTH-1];

endmodule

// File: tb/tb_eight_bit_sync_counter.sv
// Self-checking bench for eight_bit_sync_counter.
// A reference count model drives a scoreboard queue: the expected post-edge
// count is pushed when stimulus is applied and popped once the edge has occurred.

module tb_eight_bit_sync_counter;

    logic       clk;
    logic       rstn;
    logic       cnt_en;
    logic [7:0] count;
    logic       carry;

    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned pulses;

    logic [7:0] mdl;
    bit         mdl_valid;
    logic [7:0] exp_q[$];

    eight_bit_sync_counter #(.WIDTH(8)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .cnt_en (cnt_en),
        .count  (count),
        .carry  (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational carry, push the
    // expected next count, take the edge, then pop and compare.
    task automatic step(input logic r, input logic en);
        logic [7:0] nxt;
        logic [7:0] got;
        rstn   = r;
        cnt_en = en;
        #1;
        if (mdl_valid) begin
            check("carry", {31'd0, carry}, {31'd0, (en && mdl == 8'hFF)});
        end
        if (carry === 1'b1) pulses++;
        if (r)       nxt = 8'h00;
        else if (en) nxt = mdl + 8'h01;
        else         nxt = mdl;
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        if (mdl_valid || r) begin
            check("count", {24'd0, count}, {24'd0, got});
        end
        mdl       = nxt;
        mdl_valid = mdl_valid || r;
    endtask

    // Count enabled until the model reaches target (bounded to one full wrap).
    task automatic run_to(input logic [7:0] target);
        for (int k = 0; k < 256 && mdl != target; k++) step(1'b0, 1'b1);
        check("run_to", {24'd0, mdl}, {24'd0, target});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        pulses    = 0;
        mdl       = 8'h00;
        mdl_valid = 1'b0;
        rstn      = 1'b1;
        cnt_en    = 1'b0;

        // Reset for two edges.
        @(posedge clk);
        #1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("rst_count", {24'd0, count}, 32'h00);
        check("rst_carry", {31'd0, carry}, 32'h0);

        // Ten enabled edges.
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1);
        check("cnt10", {24'd0, count}, 32'h0A);
        check("cnt10_carry", {31'd0, carry}, 32'h0);

        // Up to terminal count, then wrap.
        run_to(8'hFF);
        cnt_en = 1'b1;
        #1;
        check("carry_at_ff", {31'd0, carry}, 32'h1);
        step(1'b0, 1'b1);
        check("wrap_count", {24'd0, count}, 32'h00);
        check("wrap_carry", {31'd0, carry}, 32'h0);

        // 512 enabled edges from zero: exactly two carry pulses.
        pulses = 0;
        for (int k = 0; k < 512; k++) step(1'b0, 1'b1);
        check("pulses512", pulses, 32'd2);

        // Hold at 0x37 for five edges, then resume.
        run_to(8'h37);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
        check("hold_count", {24'd0, count}, 32'h37);
        check("hold_carry", {31'd0, carry}, 32'h0);
        step(1'b0, 1'b1);
        check("resume", {24'd0, count}, 32'h38);

        // Enable gating of carry at 0xFF, no clock involved.
        run_to(8'hFF);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        cnt_en = 1'b0;
        #1;
        check("gate_off", {31'd0, carry}, 32'h0);
        cnt_en = 1'b1;
        #1;
        check("gate_on", {31'd0, carry}, 32'h1);
        check("gate_hold", {24'd0, count}, 32'hFF);

        // Reset priority over enable at 0xA5.
        run_to(8'hA5);
        step(1'b1, 1'b1);
        check("rst_prio", {24'd0, count}, 32'h00);
        step(1'b0, 1'b1);
        check("post_rst", {24'd0, count}, 32'h01);

        // Reset coinciding with terminal count: carry high, count cleared.
        run_to(8'hFF);
        step(1'b1, 1'b1);
        check("rst_at_ff", {24'd0, count}, 32'h00);

        check("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
